// File: rtl/execute_muldiv_ctrl_pkg.sv
// execute_muldiv_ctrl_pkg: shared execute-stage widths, opcode/funct codes and decode helpers
package execute_muldiv_ctrl_pkg;
  localparam int DWIDTH = 32;
  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH = 6;
  localparam logic [OPCODE_WIDTH-1:0] RTYPE = 6'h00;
  localparam logic [FUNCT_WIDTH-1:0] MFHI = 6'h10;
  localparam logic [FUNCT_WIDTH-1:0] MTHI = 6'h11;
  localparam logic [FUNCT_WIDTH-1:0] MFLO = 6'h12;
  localparam logic [FUNCT_WIDTH-1:0] MTLO = 6'h13;
  localparam logic [FUNCT_WIDTH-1:0] MULT = 6'h18;
  localparam logic [FUNCT_WIDTH-1:0] MULTU = 6'h19;
  localparam logic [FUNCT_WIDTH-1:0] DIV = 6'h1a;
  localparam logic [FUNCT_WIDTH-1:0] DIVU = 6'h1b;

  function automatic logic is_muldiv_funct(input logic [FUNCT_WIDTH-1:0] f);
    return f == MULT || f == MULTU || f == DIV || f == DIVU;
  endfunction

  function automatic logic is_md_funct(input logic [FUNCT_WIDTH-1:0] f);
    return is_muldiv_funct(f) || f == MFHI || f == MFLO || f == MTHI || f == MTLO;
  endfunction
endpackage

// File: rtl/execute_muldiv_ctrl_if.sv
// execute_muldiv_ctrl_if: execute-stage request and HI/LO result bundle of the mul/div sequencer
interface execute_muldiv_ctrl_if #(parameter int DWIDTH = execute_muldiv_ctrl_pkg::DWIDTH);
  import execute_muldiv_ctrl_pkg::*;
  logic ce;
  logic flush;
  logic [OPCODE_WIDTH-1:0] alu_op;
  logic [FUNCT_WIDTH-1:0] funct;
  logic [DWIDTH-1:0] data_rs;
  logic [DWIDTH-1:0] data_rt;
  logic stall;
  logic busy;
  logic [DWIDTH-1:0] value;
  logic value_valid;
  logic [DWIDTH-1:0] hi;
  logic [DWIDTH-1:0] lo;
  modport master(output ce, flush, alu_op, funct, data_rs, data_rt,
                 input stall, busy, value, value_valid, hi, lo);
  modport slave(input ce, flush, alu_op, funct, data_rs, data_rt,
                output stall, busy, value, value_valid, hi, lo);
endinterface

// File: rtl/execute_muldiv_ctrl_iter_core.sv
// execute_muldiv_ctrl_iter_core: one shift-add multiply or restoring-divide step on the {hi,lo} accumulator
module execute_muldiv_ctrl_iter_core #(parameter int DWIDTH = execute_muldiv_ctrl_pkg::DWIDTH) (
  input  logic              is_div,
  input  logic [DWIDTH-1:0] acc_hi,
  input  logic [DWIDTH-1:0] acc_lo,
  input  logic [DWIDTH-1:0] opnd,
  output logic [DWIDTH-1:0] nxt_hi,
  output logic [DWIDTH-1:0] nxt_lo
);
  logic [DWIDTH:0] sum, rem_sh, diff;
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc_hi, acc_lo[DWIDTH-1]};
    diff = rem_sh - {1'b0, opnd};
    // diff[DWIDTH] set means the trial subtract underflowed: restore
    nxt_hi = is_div ? (diff[DWIDTH] ? rem_sh[DWIDTH-1:0] : diff[DWIDTH-1:0]) : sum[DWIDTH:1];
    nxt_lo = is_div ? {acc_lo[DWIDTH-2:0], ~diff[DWIDTH]} : {sum[0], acc_lo[DWIDTH-1:1]};
  end
endmodule

// File: rtl/execute_muldiv_ctrl.sv
// execute_muldiv_ctrl: multi-cycle MULT/DIV sequencer owning HI/LO, serving MF/MT and stalling the pipe
module execute_muldiv_ctrl #(parameter int DWIDTH = execute_muldiv_ctrl_pkg::DWIDTH) (
  input logic md_clk,
  input logic md_rst,
  execute_muldiv_ctrl_if.slave md
);
  import execute_muldiv_ctrl_pkg::*;
  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} state_t;
  localparam int CW = $clog2(DWIDTH);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DWIDTH-1:0] hi, lo, acc_hi, acc_lo, opnd, rs_raw, nxt_hi, nxt_lo;
  logic [DWIDTH-1:0] abs_rs, abs_rt, fix_hi, fix_lo;
  logic [2*DWIDTH-1:0] prod;
  logic is_div, neg_q, neg_r, div_zero;
  logic md_op, idle, start, mf, s_rs, s_rt, div_op;

  assign md_op = md_rst && md.ce && !md.flush && md.alu_op == RTYPE && is_md_funct(md.funct);
  assign div_op = md.funct == DIV || md.funct == DIVU;
  assign s_rs = (md.funct == MULT || md.funct == DIV) && md.data_rs[DWIDTH-1];
  assign s_rt = (md.funct == MULT || md.funct == DIV) && md.data_rt[DWIDTH-1];
  assign abs_rs = s_rs ? -md.data_rs : md.data_rs;
  assign abs_rt = s_rt ? -md.data_rt : md.data_rt;

  execute_muldiv_ctrl_iter_core #(.DWIDTH(DWIDTH)) u_core (
    .is_div(is_div),
    .acc_hi(acc_hi),
    .acc_lo(acc_lo),
    .opnd(opnd),
    .nxt_hi(nxt_hi),
    .nxt_lo(nxt_lo)
  );

  always_ff @(posedge md_clk or negedge md_rst)
    if (!md_rst) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    idle = state == IDLE;
    start = md_op && idle && is_muldiv_funct(md.funct);
    mf = md_op && idle && (md.funct == MFHI || md.funct == MFLO);
    state_nxt = md.flush ? IDLE : start ? BUSY : state == FIXUP ? IDLE :
                (state == BUSY && cnt == CW'(DWIDTH - 1)) ? FIXUP : state;
    md.stall = md_op && !idle;
    md.busy = !idle;
    md.value_valid = mf;
    md.value = mf ? (md.funct == MFHI ? hi : lo) : '0;
  end

  // Divide by zero bypasses sign correction and reports the raw dividend
  always_comb begin
    prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    fix_hi = !is_div ? prod[2*DWIDTH-1:DWIDTH] : div_zero ? rs_raw : neg_r ? -acc_hi : acc_hi;
    fix_lo = !is_div ? prod[DWIDTH-1:0] : div_zero ? '1 : neg_q ? -acc_lo : acc_lo;
  end

  always_ff @(posedge md_clk or negedge md_rst)
    if (!md_rst) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd <= '0;
      rs_raw <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
        is_div <= div_op;
        acc_hi <= '0;
        acc_lo <= div_op ? abs_rs : abs_rt;
        opnd <= div_op ? abs_rt : abs_rs;
        rs_raw <= md.data_rs;
        neg_q <= s_rs ^ s_rt;
        neg_r <= s_rs;
        div_zero <= md.data_rt == '0;
      end else if (state == BUSY) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt <= cnt + 1'b1;
      end
      if (state == FIXUP && !md.flush) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (md_op && idle) begin
        if (md.funct == MTHI) hi <= md.data_rs;
        if (md.funct == MTLO) lo <= md.data_rs;
      end
    end

  assign md.hi = hi;
  assign md.lo = lo;
endmodule

// File: doc/execute_muldiv_ctrl.md
# execute_muldiv_ctrl

Multi-cycle multiply/divide sequencer attached alongside the execute stage. Accepts MULT/MULTU/DIV/DIVU from the decode/execute boundary, runs a DWIDTH-iteration shift-add or restoring-divide loop, and owns the architectural HI/LO registers. Serves MFHI/MFLO/MTHI/MTLO and raises a stall to the pipeline control while a result is pending.

## Interface
- DWIDTH, default `DWIDTH` (32): operand width; HI/LO are DWIDTH each.
- md_clk  in  1  clock, all state on rising edge.
- md_rst  in  1  reset, asynchronous, active-low.
- md_i_ce  in  1  instruction valid in execute this cycle.
- md_i_flush  in  1  abort in-flight operation (branch/exception squash).
- md_i_alu_op  in  `OPCODE_WIDTH`  opcode; only `RTYPE` is decoded.
- md_i_alu_funct  in  `FUNCT_WIDTH`  funct: `MULT`, `MULTU`, `DIV`, `DIVU`, `MFHI`, `MFLO`, `MTHI`, `MTLO`.
- md_i_data_rs, md_i_data_rt  in  DWIDTH  operands (rs = multiplicand/dividend).
- md_o_stall  out  1  hold IF/ID/EX this cycle.
- md_o_busy  out  1  operation in flight (state ≠ IDLE).
- md_o_value  out  DWIDTH  HI or LO for MFHI/MFLO, 0 otherwise.
- md_o_value_valid  out  1  md_o_value valid for writeback this cycle.
- md_o_hi, md_o_lo  out  DWIDTH  architectural HI/LO.

## Operation
- md_op = md_i_ce & (alu_op == `RTYPE`) & funct in the eight codes above. Other instructions ignored and never stalled.
- States: IDLE, BUSY, FIXUP.
- IDLE + MULT/MULTU/DIV/DIVU: latch |rs|,|rt| (signed ops) or raw (unsigned), record result signs, clear counter -> BUSY.
- BUSY: one iteration per cycle; counter 0..DWIDTH-1; at DWIDTH-1 -> FIXUP.
- Multiply: 2·DWIDTH accumulator, shift-add; MULT negates product if sign(rs)^sign(rt).
- Divide: restoring; DIV negates quotient if signs differ, remainder takes sign of rs.
- FIXUP: apply sign correction, write HI (upper/remainder), LO (lower/quotient) -> IDLE.
- Divide by zero: LO = all ones, HI = rs (raw, no fixup). DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- IDLE + MFHI/MFLO: md_o_value = HI/LO combinationally, md_o_value_valid = 1.
- IDLE + MTHI/MTLO: HI/LO <= rs at the edge; no value output.
- Any md_op while state ≠ IDLE: md_o_stall = 1, instruction not consumed; retried when IDLE.
- md_i_flush: forces IDLE next edge from any state, HI/LO unchanged; flush has priority over md_op in the same cycle (nothing accepted).
- Reset: state IDLE, counter 0, HI = LO = 0, all outputs 0.

## Timing
- Cycle 0: mul/div accepted in IDLE (no stall). Cycles 1..DWIDTH: BUSY. Cycle DWIDTH+1: FIXUP. HI/LO new value visible from cycle DWIDTH+2 (34 for DWIDTH=32).
- md_o_busy high cycles 1..DWIDTH+1.
- MFHI/MFLO issued in cycles 1..DWIDTH+1 stalls; first served in cycle DWIDTH+2 with new value.
- Back-to-back: a second mul/div is accepted at earliest in cycle DWIDTH+2.
- md_o_stall, md_o_value, md_o_value_valid are combinational from state and inputs; HI/LO and state are registered.
- Reset asserted mid-operation: immediate IDLE, HI/LO cleared, stall deasserted asynchronously.

## Structure
- Funct codes (`MULT`..`MTLO`), `RTYPE`, `DWIDTH`, `OPCODE_WIDTH`, `FUNCT_WIDTH` live in the shared parameter header with the other execute-stage defines; FSM state encodings local.
- One sub-module natural: muldiv_iter_core (one shift-add / restore-subtract step, combinational), instantiated once; FSM, counter, sign handling and HI/LO in the top.

## Test plan
- MULT rs=7, rt=-3 -> from cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy cycles 1..33.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100.
- MULTU then MFLO in cycle 1 -> stall cycles 1..33, MFLO served cycle 34 with product low; non-muldiv OR in cycle 5 -> no stall.
- MTHI rs=0x1234 in IDLE, MFHI next cycle -> md_o_value=0x1234, valid=1.
- DIV started, md_i_flush in cycle 10 -> IDLE cycle 11, HI/LO unchanged, stall low.
- MULT started, md_rst low in cycle 15 -> outputs 0 immediately, HI=LO=0, state IDLE after release.
